// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key tracker: set-2 scan codes, key bit positions,
// receive FSM states and the scan-code-to-key mapping.
package ps2_pkg;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    localparam int unsigned KEY_W     = 0;
    localparam int unsigned KEY_A     = 1;
    localparam int unsigned KEY_S     = 2;
    localparam int unsigned KEY_D     = 3;
    localparam int unsigned KEY_SPACE = 4;
    localparam int unsigned KEY_ENTER = 5;
    localparam int unsigned NUM_KEYS  = 6;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // One-hot key_status mask for a scan code; zero for codes we do not track.
    function automatic logic [NUM_KEYS-1:0] key_mask(input logic [7:0] code);
        logic [NUM_KEYS-1:0] mask;
        mask = '0;
        case (code)
            SC_W:     mask[KEY_W]     = 1'b1;
            SC_A:     mask[KEY_A]     = 1'b1;
            SC_S:     mask[KEY_S]     = 1'b1;
            SC_D:     mask[KEY_D]     = 1'b1;
            SC_SPACE: mask[KEY_SPACE] = 1'b1;
            SC_ENTER: mask[KEY_ENTER] = 1'b1;
            default:  mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, ps2_clk glitch filter and 11-bit frame FSM.
// Optional mid-frame idle timeout is compiled in with PS2_TIMEOUT_EN.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_abort
);

    localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       clk_sync_q, data_sync_q;
    logic             filt_level_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic             filt_hit, strobe, bit_in, timeout_hit;

    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;

    // Pins idle high, so synchronisers and the filtered level reset to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    assign bit_in   = data_sync_q[1];
    assign filt_hit = (clk_sync_q[1] != filt_level_q) &&
                      (filt_cnt_q == FiltW'(FILTER_LEN - 1));
    assign strobe   = filt_hit && filt_level_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_level_q <= 1'b1;
            filt_cnt_q   <= '0;
        end else if (clk_sync_q[1] == filt_level_q) begin
            filt_cnt_q   <= '0;
        end else if (filt_hit) begin
            filt_level_q <= clk_sync_q[1];
            filt_cnt_q   <= '0;
        end else begin
            filt_cnt_q   <= filt_cnt_q + 1'b1;
        end
    end

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    logic [ToW-1:0] to_cnt_q;

    // Counts cycles since the last strobe while a frame is in flight.
    assign timeout_hit = (state_q != RX_IDLE) && !strobe &&
                         (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else if ((state_q == RX_IDLE) || strobe || timeout_hit) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        rx_valid  = 1'b0;
        rx_err    = 1'b0;
        rx_abort  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (strobe && !bit_in) begin
                    state_d   = RX_DATA;
                    bit_cnt_d = '0;
                end
            end
            RX_DATA: begin
                if (strobe) begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
            end
            RX_PARITY: begin
                if (strobe) begin
                    parity_d = bit_in;
                    state_d  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (strobe) begin
                    state_d = RX_IDLE;
                    if (bit_in && (^{shift_q, parity_q})) begin
                        rx_valid = 1'b1;
                    end else begin
                        rx_err = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
        if (timeout_hit) begin
            state_d  = RX_IDLE;
            rx_err   = 1'b1;
            rx_abort = 1'b1;
        end
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard tracker: decodes make/break/extended prefixes into a six-key held-state map.
// Build with PS2_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYCLES.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_status,
    output logic [7:0]          scan_code,
    output logic                code_valid,
    output logic                frame_err
);

    logic [7:0]          rx_byte;
    logic                rx_valid, rx_err, rx_abort;
    logic [NUM_KEYS-1:0] key_q, key_d;
    logic [7:0]          code_q, code_d;
    logic                ext_q, ext_d, brk_q, brk_d;
    logic                valid_q, err_q;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rx_abort (rx_abort)
    );

    // Byte, pulse and key map all register on the stop-bit strobe so they appear together.
    always_comb begin
        key_d  = key_q;
        code_d = code_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        if (rx_valid) begin
            code_d = rx_byte;
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                if (!ext_q) begin
                    key_d = brk_q ? (key_q & ~key_mask(rx_byte)) : (key_q | key_mask(rx_byte));
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        if (rx_abort) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q   <= '0;
            code_q  <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            key_q   <= key_d;
            code_q  <= code_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            valid_q <= rx_valid;
            err_q   <= rx_err;
        end
    end

    assign key_status = key_q;
    assign scan_code  = code_q;
    assign code_valid = valid_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed frames, then random frames against a
// scan-code-level model of the key map. Timeout scenario runs only with PS2_TIMEOUT_EN.
module tb_ps2_key_tracker;

    localparam int unsigned FILT = 8;
    localparam int unsigned TO   = 3000;
    localparam int unsigned HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [5:0] key_status;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_key_tracker #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_status (key_status),
        .scan_code  (scan_code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_valid = 0;
    int unsigned n_err = 0;
    int unsigned valid_cyc = 0;
    logic [5:0]  ks_at_valid = '0;
    always @(negedge clk) begin
        if (code_valid) begin
            n_valid     <= n_valid + 1;
            valid_cyc   <= cyc;
            ks_at_valid <= key_status;
        end
        if (frame_err) n_err <= n_err + 1;
    end

    int tests = 0;
    int fails = 0;
    int unsigned stop_fall_cyc = 0;

    // Reference model: key map, prefix flags and last accepted byte.
    logic [7:0] key_codes [6] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A};
    logic [5:0] m_keys = '0;
    logic [7:0] m_code = '0;
    bit         m_ext = 0;
    bit         m_brk = 0;

    function automatic void model_accept(input logic [7:0] b);
        m_code = b;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (!m_ext && key_codes[k] == b) m_keys[k] = !m_brk;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic v);
        @(negedge clk);
        ps2_data = v;
        repeat (HALF / 2) @(negedge clk);
        ps2_clk = 1'b0;
        stop_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF / 2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] b, input bit bad_par);
        int unsigned v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame(b, bad_par);
        repeat (20) @(negedge clk);
        if (!bad_par) model_accept(b);
        check({tag, ".valid_cnt"}, n_valid - v0, bad_par ? 0 : 1);
        check({tag, ".err_cnt"}, n_err - e0, bad_par ? 1 : 0);
        check({tag, ".scan_code"}, {24'd0, scan_code}, {24'd0, m_code});
        check({tag, ".key_status"}, {26'd0, key_status}, {26'd0, m_keys});
        if (!bad_par) begin
            check({tag, ".keys_with_valid"}, {26'd0, ks_at_valid}, {26'd0, m_keys});
            check({tag, ".latency"}, valid_cyc - stop_fall_cyc, FILT + 2);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".key_status"}, {26'd0, key_status}, 0);
        check({tag, ".scan_code"}, {24'd0, scan_code}, 0);
        check({tag, ".code_valid"}, {31'd0, code_valid}, 0);
        check({tag, ".frame_err"}, {31'd0, frame_err}, 0);
    endtask

    initial begin
        int unsigned v0, e0, r;
        logic [7:0]  b;
        bit          bad;

        repeat (5) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (10) @(negedge clk);

        frame_check("make_w", 8'h1D, 0);
        frame_check("brk_pfx", 8'hF0, 0);
        frame_check("break_w", 8'h1D, 0);
        frame_check("make_w2", 8'h1D, 0);
        frame_check("make_d", 8'h23, 0);
        check("w_and_d", {26'd0, key_status}, 32'b001001);
        frame_check("brk_pfx2", 8'hF0, 0);
        frame_check("break_d", 8'h23, 0);
        frame_check("bad_parity", 8'h1C, 1);
        frame_check("brk_pfx3", 8'hF0, 0);
        frame_check("break_w2", 8'h1D, 0);
        frame_check("ext_pfx", 8'hE0, 0);
        frame_check("ext_w", 8'h1D, 0);
        frame_check("plain_w", 8'h1D, 0);
        check("w_after_ext", {31'd0, key_status[0]}, 1);

        // A lone clock pulse with data high must be ignored in idle.
        v0 = n_valid;
        e0 = n_err;
        ps2_bit(1'b1);
        repeat (20) @(negedge clk);
        check("spurious.valid_cnt", n_valid - v0, 0);
        check("spurious.err_cnt", n_err - e0, 0);

        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) b = key_codes[r];
            else if (r == 6) b = 8'hE0;
            else if (r == 7) b = 8'hF0;
            else if (r == 8) b = 8'($urandom_range(0, 255));
            else b = key_codes[$urandom_range(0, 5)];
            bad = ($urandom_range(0, 7) == 0);
            frame_check($sformatf("rand%0d", n), b, bad);
        end

`ifdef PS2_TIMEOUT_EN
        frame_check("to_ext_pfx", 8'hE0, 0);
        v0 = n_valid;
        e0 = n_err;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
        repeat (TO + 100) @(negedge clk);
        check("timeout.err_cnt", n_err - e0, 1);
        check("timeout.valid_cnt", n_valid - v0, 0);
        m_ext = 0;
        m_brk = 0;
        frame_check("after_timeout", 8'h29, 0);
        check("space_after_timeout", {31'd0, key_status[4]}, 1);
`endif

        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("mid_reset");
        reset = 1'b1;
        m_keys = '0;
        m_code = '0;
        m_ext  = 0;
        m_brk  = 0;
        repeat (10) @(negedge clk);
        frame_check("after_reset", 8'h29, 0);
        check("space_after_reset", {26'd0, key_status}, 32'b010000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
